// File: rtl/nv_ram_fifo_ctrl_128x16_if.sv
// Producer/consumer handshake bundle for the 128x16 RAM FIFO controller.
// master drives pushes and pop-ready; slave is the controller.
interface nv_ram_fifo_ctrl_128x16_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [7:0]  occupancy;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, occupancy
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, occupancy
    );
endinterface

// File: rtl/nv_ram_fifo_ctrl_128x16.sv
// Turns a 128x16 registered-read two-port RAM into a valid/ready FIFO.
// A 4-entry skid buffer hides the re -> ore -> dout read pipeline.
module nv_ram_fifo_ctrl_128x16 (
    input  logic        clk,
    input  logic        rst,
    nv_ram_fifo_ctrl_128x16_if.slave bus,
    output logic [6:0]  ram_wa,
    output logic        ram_we,
    output logic [15:0] ram_di,
    output logic [6:0]  ram_ra,
    output logic        ram_re,
    output logic        ram_ore,
    input  logic [15:0] ram_dout,
    input  logic [31:0] pwrbus_ram_pd,
    output logic [31:0] ram_pwrbus_pd
);
    logic [6:0]       wp;
    logic [6:0]       rp;
    logic [7:0]       ram_cnt;
    logic             v1;
    logic             v2;
    logic [3:0][15:0] skid;
    logic [3:0][15:0] skid_nxt;
    logic [2:0]       skid_cnt;
    logic [2:0]       in_flight;
    logic [1:0]       cap_idx;
    logic             push;
    logic             pop;
    logic             issue;

    // Issue only when every read already in flight still has a skid slot.
    assign in_flight = skid_cnt + {2'b0, v1} + {2'b0, v2};
    assign issue     = !rst && ram_cnt != 8'd0 && in_flight < 3'd4;
    assign push      = bus.wr_valid & bus.wr_ready;
    assign pop       = bus.rd_valid & bus.rd_ready;
    assign cap_idx   = 2'(skid_cnt - {2'b0, pop});

    assign bus.wr_ready  = !rst && ram_cnt != 8'd128;
    assign bus.rd_valid  = skid_cnt != 3'd0;
    assign bus.rd_data   = skid[0];
    assign bus.occupancy = ram_cnt + {7'b0, v1} + {7'b0, v2}
                         + {5'b0, skid_cnt};

    assign ram_wa        = wp;
    assign ram_we        = push;
    assign ram_di        = bus.wr_data;
    assign ram_ra        = rp;
    assign ram_re        = issue;
    assign ram_ore       = v1 && !rst;
    assign ram_pwrbus_pd = pwrbus_ram_pd;

    // Shift only live entries so rd_data holds once the skid empties.
    always_comb begin
        skid_nxt = skid;
        if (pop) begin
            for (int i = 0; i < 3; i++) begin
                if (3'(i + 1) < skid_cnt) skid_nxt[i] = skid[i + 1];
            end
        end
        if (v2) skid_nxt[cap_idx] = ram_dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            ram_cnt  <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            skid_cnt <= '0;
            skid     <= '0;
        end else begin
            if (push)  wp <= wp + 7'd1;
            if (issue) rp <= rp + 7'd1;
            ram_cnt  <= ram_cnt + {7'b0, push} - {7'b0, issue};
            v1       <= issue;
            v2       <= v1;
            skid_cnt <= skid_cnt + {2'b0, v2} - {2'b0, pop};
            skid     <= skid_nxt;
        end
    end
endmodule
